// File: rtl/lock_pkg.sv
// lock_pkg: FSM state encoding and default code/wait/retry sizes shared by sender and detector
package lock_pkg;
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
  localparam int CODE_W_DEF = 4;
  localparam int WAIT_CYC_DEF = 3;
  localparam int MAX_TRY_DEF = 3;
endpackage

// File: rtl/lock_code_shifter.sv
// lock_code_shifter: MSB-first rotating code register (clk, reset active-low, load/shift in, din code, q current bit, last_bit on LSB)
module lock_code_shifter import lock_pkg::*; #(
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [CODE_W-1:0] din,
  output logic              q,
  output logic              last_bit
);
  localparam int IW = CODE_W > 1 ? $clog2(CODE_W) : 1;
  logic [CODE_W-1:0] data;
  logic [IW-1:0] idx;
  assign q = data[CODE_W-1];
  assign last_bit = idx == '0;
  always_ff @(posedge clk)
    if (!reset) begin
      data <= '0;
      idx <= IW'(CODE_W - 1);
    end else if (load) begin
      data <= din;
      idx <= IW'(CODE_W - 1);
    end else if (shift) begin
      data <= (data << 1) | (data >> (CODE_W - 1));
      idx <= last_bit ? IW'(CODE_W - 1) : idx - 1'b1;
    end
endmodule

// File: rtl/lock_code_sender.sv
// lock_code_sender: sends a serial unlock code with retries (clk, reset active-low, start/code/unlock in; d, busy, done, pass, tries out)
module lock_code_sender import lock_pkg::*; #(
  parameter int   CODE_W     = CODE_W_DEF,
  parameter int   WAIT_CYC   = WAIT_CYC_DEF,
  parameter int   MAX_TRY    = MAX_TRY_DEF,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [CODE_W-1:0]            code,
  input  logic                         unlock,
  output logic                         d,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [$clog2(MAX_TRY+1)-1:0] tries
);
  localparam int TW = $clog2(MAX_TRY + 1);
  localparam int WW = $clog2(WAIT_CYC + 1);
  state_t state, state_nx;
  logic [WW-1:0] wait_cnt;
  logic q, last_bit, accept, hit, expire, retry, fin;
  lock_code_shifter #(.CODE_W(CODE_W)) u_shifter (
    .clk(clk),
    .reset(reset),
    .load(accept),
    .shift(state == SEND),
    .din(code),
    .q(q),
    .last_bit(last_bit)
  );
  always_comb begin
    accept = state == IDLE && start;
    hit = unlock && (state == WAIT || (state == SEND && last_bit));
    expire = state == WAIT && wait_cnt == WW'(WAIT_CYC - 1);
    retry = expire && !hit && tries != TW'(MAX_TRY);
    fin = hit || (expire && !retry);
  end
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = accept ? SEND :
               fin ? IDLE :
               retry ? SEND :
               (state == SEND && last_bit) ? WAIT : state;
  always_comb begin
    busy = state != IDLE;
    d = state == SEND ? q : IDLE_LEVEL;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      done <= 1'b0;
      pass <= 1'b0;
      tries <= '0;
      wait_cnt <= '0;
    end else begin
      done <= fin;
      pass <= hit;
      tries <= accept ? TW'(1) : retry ? tries + 1'b1 : tries;
      wait_cnt <= state == WAIT ? wait_cnt + 1'b1 : '0;
    end
endmodule

// File: tb/tb_lock_code_sender.sv
// tb_lock_code_sender: randomized transaction-level check of lock_code_sender against a timeline model
module tb_lock_code_sender;
  localparam int CW = 4, WC = 3, MT = 3, P = CW + WC;
  localparam logic IL = 1'b0;
  logic clk = 0, reset = 0, start = 0, unlock = 0;
  logic [CW-1:0] code = '0;
  logic d, busy, done, pass;
  logic [1:0] tries;
  int checks = 0, errors = 0;
  logic [1:0] held_tries = '0;
  lock_code_sender #(.CODE_W(CW), .WAIT_CYC(WC), .MAX_TRY(MT), .IDLE_LEVEL(IL)) dut (
    .clk(clk), .reset(reset), .start(start), .code(code), .unlock(unlock),
    .d(d), .busy(busy), .done(done), .pass(pass), .tries(tries)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int ru();
    int r = $urandom_range(0, WC + 2);
    return r > WC ? -1 : r;
  endfunction
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("idle_d", d, IL);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_pass", pass, 0);
      chk("idle_tries", tries, held_tries);
      start = 0;
      unlock = $urandom;
      code = $urandom;
    end
  endtask
  // u[a]: cycle of attempt a's unlock window that carries unlock (0 = LSB cycle, k = k-th wait cycle, -1 = none)
  task automatic request(input logic [CW-1:0] c, input int u0, input int u1, input int u2,
                         input bit b2b, input logic [CW-1:0] nc);
    int u[3];
    int dc, tgt, et, a, i;
    bit ep;
    u = '{u0, u1, u2};
    dc = MT * P + 1;
    ep = 0;
    et = MT;
    tgt = -1;
    for (int k = 0; k < MT; k++)
      if (u[k] >= 0) begin
        tgt = k * P + CW + u[k];
        dc = tgt + 1;
        ep = 1;
        et = k + 1;
        break;
      end
    for (int t = 1; t <= dc; t++) begin
      @(negedge clk);
      a = (t - 1) / P;
      i = (t - 1) % P;
      if (t < dc) begin
        chk("busy", busy, 1);
        chk("done_low", done, 0);
        chk("pass_low", pass, 0);
        chk("d_bit", d, i < CW ? c[CW-1-i] : IL);
        chk("tries_run", tries, a + 1);
      end else begin
        chk("end_busy", busy, 0);
        chk("done", done, 1);
        chk("pass", pass, ep);
        chk("tries_end", tries, et);
        chk("end_d", d, IL);
        held_tries = 2'(et);
      end
      start = t < dc ? 1'($urandom) : b2b;
      code = (t == dc && b2b) ? nc : CW'($urandom);
      unlock = (t < dc && i >= CW - 1) ? (t == tgt) : 1'($urandom);
    end
    if (!b2b) start = 0;
  endtask
  initial begin
    bit pend;
    bit nb;
    logic [CW-1:0] cc, nc;
    code = $urandom;
    repeat (2) @(negedge clk);
    chk("rst_d", d, IL);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_tries", tries, 0);
    reset = 1;
    idle(2);
    start = 1; code = 4'b0111;
    request(4'b0111, 1, -1, -1, 0, '0);
    idle(2);
    start = 1; code = 4'b0111;
    request(4'b0111, -1, -1, -1, 0, '0);
    idle(1);
    start = 1; code = 4'b1100;
    request(4'b1100, -1, 1, -1, 1, 4'b1010);
    request(4'b1010, 0, -1, -1, 0, '0);
    idle(1);
    start = 1; code = 4'b0111; unlock = 0;
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      chk("rs_busy", busy, 1);
      chk("rs_d", d, t == 1 ? 0 : 1);
      start = 0;
    end
    reset = 0;
    @(negedge clk);
    chk("rs_abort_d", d, IL);
    chk("rs_abort_busy", busy, 0);
    chk("rs_abort_tries", tries, 0);
    chk("rs_abort_done", done, 0);
    reset = 1;
    held_tries = '0;
    idle(3);
    pend = 0;
    nc = '0;
    for (int n = 0; n < 40; n++) begin
      if (!pend) begin
        idle($urandom_range(0, 2));
        cc = $urandom;
        start = 1;
        code = cc;
      end else cc = nc;
      nb = n == 39 ? 1'b0 : 1'($urandom);
      nc = $urandom;
      request(cc, ru(), ru(), ru(), nb, nc);
      pend = nb;
    end
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lock_code_sender.md
LOCK_CODE_SENDER -- requirements
Module: lock_code_sender

Interface
REQ-001 Parameter CODE_W, default 4: length of the serial unlock code in bits.
REQ-002 Parameter WAIT_CYC, default 3: number of post-code cycles in which unlock is awaited.
REQ-003 Parameter MAX_TRY, default 3: maximum number of code transmissions per start.
REQ-004 Parameter IDLE_LEVEL, default 0: level driven on d whenever no code bit is being sent.
REQ-005 clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-low reset; reset=0 sampled at a rising edge resets the block.
REQ-007 start  in  1  request to send code; accepted only when busy=0.
REQ-008 code  in  CODE_W  code to send, MSB first; sampled only on the accepting edge.
REQ-009 unlock  in  1  unlock indication from the detector at the far end of d.
REQ-010 d  out  1  serial data to the detector, one bit per clock.
REQ-011 busy  out  1  high while sending or awaiting unlock.
REQ-012 done  out  1  one-cycle pulse marking the end of a request.
REQ-013 pass  out  1  result qualifier, valid while done=1: 1 means unlock was seen.
REQ-014 tries  out  $clog2(MAX_TRY+1)  number of transmissions made for the current or last request.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, SEND and WAIT.
REQ-016 In IDLE with start=1, the next edge SHALL capture code, set tries=1, clear the bit index to CODE_W-1 and enter SEND.
REQ-017 In SEND, d SHALL equal captured_code[bit index], with the MSB in the first SEND cycle and exactly CODE_W cycles per transmission.
REQ-018 After the LSB cycle the FSM SHALL enter WAIT and drive d=IDLE_LEVEL for up to WAIT_CYC cycles.
REQ-019 unlock SHALL be sampled in the LSB cycle of SEND and in every WAIT cycle; unlock at any other time is ignored.
REQ-020 On a sampled unlock=1, the next edge SHALL enter IDLE with done=1 and pass=1 for that one cycle.
REQ-021 If WAIT expires without unlock and tries<MAX_TRY, the FSM SHALL re-enter SEND with the same captured code and increment tries.
REQ-022 If WAIT expires without unlock and tries=MAX_TRY, the FSM SHALL enter IDLE with done=1 and pass=0 for one cycle.
REQ-023 busy SHALL be 1 exactly in SEND and WAIT; d SHALL be IDLE_LEVEL in IDLE and WAIT.
REQ-024 start while busy=1 SHALL be ignored, and a change of code while busy=1 SHALL not affect transmission.
REQ-025 start in the done cycle SHALL be accepted, giving back-to-back requests with no gap cycle.
REQ-026 tries SHALL hold its final value after done until the next accepted start.
REQ-027 pass SHALL be 0 whenever done=0.
REQ-028 All outputs SHALL be registered or decoded only from state; there SHALL be no combinational path from unlock to d.

Reset
REQ-029 reset=0 SHALL force, on the next edge and from any state, IDLE, d=IDLE_LEVEL, busy=0, done=0, pass=0, tries=0 and the captured code to 0.
REQ-030 Reset asserted mid-transmission SHALL abort the transmission without a done pulse.

Structure
REQ-031 Package lock_pkg SHALL hold the FSM state enum and the default values of CODE_W, WAIT_CYC and MAX_TRY, shared with the detector.
REQ-032 The block SHALL contain one sub-module, lock_code_shifter, a loadable MSB-first shift register with a bit counter and a last_bit flag.

Verification
REQ-033 code=4'b0111, detector unlock high one cycle after the LSB -> d=0,1,1,1; done with pass=1 and tries=1 five cycles after start acceptance.
REQ-034 code=4'b0111, unlock held 0 -> three transmissions, busy high 21 cycles, then done with pass=0 and tries=3.
REQ-035 unlock asserted only in the first WAIT cycle of attempt 2 -> done with pass=1, tries=2, and no third SEND.
REQ-036 reset=0 in the third SEND cycle -> next cycle d=0, busy=0, tries=0, and no done pulse.
REQ-037 start pulsed mid-SEND with code=4'b1010 -> ignored and the d sequence unchanged; start in the done cycle with code=4'b1010 -> d=1,0,1,0 starting with the next cycle.
